// File: rtl/phy_serial_pattern_gen.sv
// Multi-lane serial stimulus generator: per-lane word FIFOs serialised MSB-first on one shared slot timer.
// Empty lanes fill their slot with IDLE; writes to a full lane that is not popping are dropped and flagged sticky.
module phy_serial_pattern_gen #(
    parameter int               LANES = 2,
    parameter int               WIDTH = 8,
    parameter int               DEPTH = 4,
    parameter logic [WIDTH-1:0] IDLE  = WIDTH'(8'hBC)
) (
    input  logic                                     clk_8f,
    input  logic                                     reset_L,
    input  logic                                     enable,
    input  logic                                     wr_en,
    input  logic [((LANES > 1) ? $clog2(LANES) : 1)-1:0] wr_lane,
    input  logic [WIDTH-1:0]                         wr_data,
    output logic [LANES-1:0]                         wr_full,
    output logic [LANES-1:0]                         overflow,
    output logic [LANES-1:0]                         out_serial,
    output logic [LANES-1:0]                         out_valid,
    output logic [LANES-1:0]                         word_start
);

    localparam int LW = (LANES > 1) ? $clog2(LANES) : 1;
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam int BW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

    logic [WIDTH-1:0] mem_q     [LANES][DEPTH];
    logic [PW-1:0]    rd_ptr_q  [LANES];
    logic [PW-1:0]    wr_ptr_q  [LANES];
    logic [CW-1:0]    count_q   [LANES];
    logic [CW-1:0]    count_d   [LANES];
    logic [WIDTH-1:0] shift_q   [LANES];
    logic [WIDTH-1:0] load_word [LANES];
    logic [BW-1:0]    bit_cnt_q;
    logic [BW-1:0]    bit_cnt_d;
    logic [LANES-1:0] serial_q, valid_q, start_q, ovf_q;
    logic [LANES-1:0] full, pop, push, drop, sel;
    logic             slot_load;

    always_comb begin
        slot_load = enable && (bit_cnt_q == '0);
        bit_cnt_d = '0;
        sel       = '0;
        full      = '0;
        pop       = '0;
        push      = '0;
        drop      = '0;
        if (enable && (bit_cnt_q != BW'(WIDTH - 1))) begin
            bit_cnt_d = bit_cnt_q + BW'(1);
        end
        for (int l = 0; l < LANES; l++) begin
            sel[l]       = wr_en && (wr_lane == LW'(l));
            full[l]      = (count_q[l] == CW'(DEPTH));
            pop[l]       = slot_load && (count_q[l] != '0);
            // A full lane can still take a write when its head leaves at the same edge.
            push[l]      = sel[l] && (!full[l] || pop[l]);
            drop[l]      = sel[l] && full[l] && !pop[l];
            load_word[l] = pop[l] ? mem_q[l][rd_ptr_q[l]] : IDLE;
            count_d[l]   = count_q[l] + CW'(push[l]) - CW'(pop[l]);
        end
    end

    always_ff @(posedge clk_8f) begin
        if (!reset_L) begin
            bit_cnt_q <= '0;
            serial_q  <= '0;
            valid_q   <= '0;
            start_q   <= '0;
            ovf_q     <= '0;
            for (int l = 0; l < LANES; l++) begin
                rd_ptr_q[l] <= '0;
                wr_ptr_q[l] <= '0;
                count_q[l]  <= '0;
                shift_q[l]  <= '0;
            end
        end else begin
            bit_cnt_q <= bit_cnt_d;
            ovf_q     <= ovf_q | drop;
            for (int l = 0; l < LANES; l++) begin
                count_q[l] <= count_d[l];
                if (push[l]) wr_ptr_q[l] <= wr_ptr_q[l] + PW'(1);
                if (pop[l])  rd_ptr_q[l] <= rd_ptr_q[l] + PW'(1);
                if (!enable) begin
                    serial_q[l] <= 1'b0;
                    valid_q[l]  <= 1'b0;
                    start_q[l]  <= 1'b0;
                end else if (slot_load) begin
                    serial_q[l] <= load_word[l][WIDTH-1];
                    shift_q[l]  <= load_word[l] << 1;
                    valid_q[l]  <= pop[l];
                    start_q[l]  <= 1'b1;
                end else begin
                    serial_q[l] <= shift_q[l][WIDTH-1];
                    shift_q[l]  <= shift_q[l] << 1;
                    start_q[l]  <= 1'b0;
                end
            end
        end
    end

    // Storage needs no reset: pointers and counts define what is live.
    always_ff @(posedge clk_8f) begin
        for (int l = 0; l < LANES; l++) begin
            if (reset_L && push[l]) mem_q[l][wr_ptr_q[l]] <= wr_data;
        end
    end

    assign wr_full    = full;
    assign overflow   = ovf_q;
    assign out_serial = serial_q;
    assign out_valid  = valid_q;
    assign word_start = start_q;

endmodule

// File: tb/tb_phy_serial_pattern_gen.sv
// Directed bench for phy_serial_pattern_gen: stimulus pushes per-cycle expectations, a negedge monitor pops and compares.
module tb_phy_serial_pattern_gen;

    logic       clk_8f = 1'b0;
    logic       reset_L, enable, wr_en;
    logic [0:0] wr_lane;
    logic [7:0] wr_data;
    logic [1:0] wr_full, overflow, out_serial, out_valid, word_start;

    phy_serial_pattern_gen dut (
        .clk_8f    (clk_8f),
        .reset_L   (reset_L),
        .enable    (enable),
        .wr_en     (wr_en),
        .wr_lane   (wr_lane),
        .wr_data   (wr_data),
        .wr_full   (wr_full),
        .overflow  (overflow),
        .out_serial(out_serial),
        .out_valid (out_valid),
        .word_start(word_start)
    );

    always #5 clk_8f = ~clk_8f;

    typedef struct {
        logic [1:0] ser;
        logic [1:0] vld;
        logic [1:0] ws;
        logic [1:0] full;
        logic [1:0] ovf;
        string      nm;
    } exp_t;

    exp_t       sb[$];
    int         total = 0;
    int         bad   = 0;
    logic [1:0] exp_full = 2'b00;
    logic [1:0] exp_ovf  = 2'b00;

    // One clock edge; the expectation describes the cycle that follows it.
    task automatic tick(input logic [1:0] ser, input logic [1:0] vld, input logic [1:0] ws, input string nm);
        exp_t e;
        @(posedge clk_8f);
        #1;
        e.ser  = ser;
        e.vld  = vld;
        e.ws   = ws;
        e.full = exp_full;
        e.ovf  = exp_ovf;
        e.nm   = nm;
        sb.push_back(e);
    endtask

    task automatic quiet(input int n, input string nm);
        for (int i = 0; i < n; i++) tick(2'b00, 2'b00, 2'b00, nm);
    endtask

    task automatic slot(input logic [7:0] w0, input logic v0, input logic [7:0] w1, input logic v1,
                        input int nbits, input string nm);
        for (int k = 0; k < nbits; k++) begin
            tick({w1[7-k], w0[7-k]}, {v1, v0}, (k == 0) ? 2'b11 : 2'b00, nm);
            wr_en = 1'b0;
        end
    endtask

    task automatic write(input logic lane, input logic [7:0] d, input string nm);
        wr_en   = 1'b1;
        wr_lane = lane;
        wr_data = d;
        quiet(1, nm);
        wr_en   = 1'b0;
    endtask

    always @(negedge clk_8f) begin
        if (sb.size() > 0) begin
            exp_t e;
            e = sb.pop_front();
            total++;
            if ({out_serial, out_valid, word_start, wr_full, overflow} !== {e.ser, e.vld, e.ws, e.full, e.ovf}) begin
                bad++;
                $display("FAIL %s @%0t: got ser=%b vld=%b ws=%b full=%b ovf=%b, want ser=%b vld=%b ws=%b full=%b ovf=%b",
                         e.nm, $time, out_serial, out_valid, word_start, wr_full, overflow,
                         e.ser, e.vld, e.ws, e.full, e.ovf);
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not complete, pending=%0d", sb.size());
        $fatal(1, "watchdog");
    end

    initial begin
        reset_L = 1'b0;
        enable  = 1'b0;
        wr_en   = 1'b0;
        wr_lane = 1'b0;
        wr_data = 8'h00;

        // Reset then free-running IDLE
        quiet(3, "reset");
        reset_L = 1'b1;
        enable  = 1'b1;
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "idle1");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "idle2");

        // Single word queued while disabled
        enable = 1'b0;
        write(1'b0, 8'hA5, "wr_a5");
        enable = 1'b1;
        slot(8'hA5, 1'b1, 8'hBC, 1'b0, 8, "single");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "single_post");

        // Multi-lane alignment
        enable = 1'b0;
        write(1'b0, 8'h0F, "wr_0f");
        write(1'b0, 8'hF0, "wr_f0");
        write(1'b1, 8'h3C, "wr_3c");
        enable = 1'b1;
        slot(8'h0F, 1'b1, 8'h3C, 1'b1, 8, "multi1");
        slot(8'hF0, 1'b1, 8'hBC, 1'b0, 8, "multi2");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "multi3");

        // Fill lane 1 and overflow it
        enable = 1'b0;
        write(1'b1, 8'h11, "fill1");
        write(1'b1, 8'h22, "fill2");
        write(1'b1, 8'h33, "fill3");
        exp_full = 2'b10;
        write(1'b1, 8'h44, "fill4");
        exp_ovf = 2'b10;
        write(1'b1, 8'h55, "fill5_drop");
        enable   = 1'b1;
        exp_full = 2'b00;
        slot(8'hBC, 1'b0, 8'h11, 1'b1, 8, "drain1");
        slot(8'hBC, 1'b0, 8'h22, 1'b1, 8, "drain2");
        slot(8'hBC, 1'b0, 8'h33, 1'b1, 8, "drain3");
        slot(8'hBC, 1'b0, 8'h44, 1'b1, 8, "drain4");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "drain_idle");

        // Push into full lane 0 at the edge that pops it
        enable = 1'b0;
        write(1'b0, 8'h61, "fullp1");
        write(1'b0, 8'h62, "fullp2");
        write(1'b0, 8'h63, "fullp3");
        exp_full = 2'b01;
        write(1'b0, 8'h64, "fullp4");
        enable  = 1'b1;
        wr_en   = 1'b1;
        wr_lane = 1'b0;
        wr_data = 8'h65;
        slot(8'h61, 1'b1, 8'hBC, 1'b0, 8, "pushpop");
        exp_full = 2'b00;
        slot(8'h62, 1'b1, 8'hBC, 1'b0, 8, "pp2");
        slot(8'h63, 1'b1, 8'hBC, 1'b0, 8, "pp3");
        slot(8'h64, 1'b1, 8'hBC, 1'b0, 8, "pp4");
        slot(8'h65, 1'b1, 8'hBC, 1'b0, 8, "pp5");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "pp_idle");

        // Abort by enable drop at bit 3
        enable = 1'b0;
        write(1'b0, 8'h55, "wr_55");
        write(1'b0, 8'h66, "wr_66");
        enable = 1'b1;
        slot(8'h55, 1'b1, 8'hBC, 1'b0, 4, "abort_part");
        enable = 1'b0;
        quiet(5, "abort_low");
        enable = 1'b1;
        slot(8'h66, 1'b1, 8'hBC, 1'b0, 8, "abort_next");
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "abort_idle");

        // Reset mid-slot discards queued data and clears overflow
        enable = 1'b0;
        write(1'b0, 8'h77, "wr_77");
        write(1'b0, 8'h78, "wr_78");
        enable = 1'b1;
        slot(8'h77, 1'b1, 8'hBC, 1'b0, 3, "rst_part");
        reset_L = 1'b0;
        exp_ovf = 2'b00;
        quiet(1, "rst_mid");
        reset_L = 1'b1;
        slot(8'hBC, 1'b0, 8'hBC, 1'b0, 8, "rst_after");

        for (int i = 0; i < 10 && sb.size() > 0; i++) @(negedge clk_8f);
        #1;
        if (sb.size() > 0) begin
            bad++;
            $display("FAIL drain: pending=%0d, want 0", sb.size());
        end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/phy_serial_pattern_gen.md
Name: phy_serial_pattern_gen

Overview:
Synthesisable, parametrised multi-lane serial stimulus generator for the PHY receive path, running in the clk_8f domain. Each lane buffers parallel words written by a host port and serialises them MSB-first onto its serial line. All lanes share one slot timer, so word boundaries are aligned across lanes. A lane with no buffered word transmits the IDLE word, which lets phy_rx benches and on-chip self-test drive N lanes with arbitrary data and idle insertion.

Parameters:
LANES, 2, number of serial lanes (1..8).
WIDTH, 8, bits per word.
DEPTH, 4, words buffered per lane (power of two, >=2).
IDLE, 8'hBC, word sent when a lane's buffer is empty (WIDTH bits).

Ports:
clk_8f  in  1  serial bit clock; all logic on rising edge.
reset_L  in  1  synchronous, active-low reset.
enable  in  1  generator run enable.
wr_en  in  1  host write strobe.
wr_lane  in  max(1,$clog2(LANES))  target lane of the write.
wr_data  in  WIDTH  word to queue.
wr_full  out  LANES  per-lane buffer full (combinational, count==DEPTH).
overflow  out  LANES  sticky: a write was dropped on that lane.
out_serial  out  LANES  serial data, one bit per lane.
out_valid  out  LANES  1 while the lane's current slot carries a buffered word, 0 during IDLE.
word_start  out  LANES  1 during the first bit (MSB) of every slot, data or IDLE.

Behaviour:
- Interface: one clock (clk_8f); reset_L is synchronous and active-low.
- Reset (reset_L=0 at an edge): all FIFOs are emptied; bit_cnt=0; out_serial, out_valid, word_start and overflow are 0. A reset in mid-word aborts the word and discards all queued data.
- Shared bit_cnt runs 0..WIDTH-1 and wraps. It advances only at edges with enable=1. With enable=0 it is forced to 0 and all outputs are driven to 0. FIFO contents are kept, and writes are still accepted.
- Slot load: at an edge with enable=1 and bit_cnt==0, each lane loads its shift register. If the lane FIFO is non-empty, it pops the head word and sets out_valid=1. Otherwise it loads IDLE and sets out_valid=0.
- At the same edge, out_serial is set to the MSB of the loaded word and word_start=1.
- At an edge with bit_cnt==k (k>0), out_serial is set to bit WIDTH-1-k of the slot word and word_start=0. out_valid holds for the whole slot.
- Bit k of a slot is therefore visible in the cycle after the edge with bit_cnt==k. A slot lasts exactly WIDTH cycles.
- Minimum latency: a word written at edge t, into an empty lane, with bit_cnt==0 at edge t+1, appears as its MSB after edge t+1.
- Deasserting enable mid-slot aborts the slot. The word in progress is lost and is not re-queued. When enable is reasserted, the next edge starts a fresh slot.
- Writes: at an edge with wr_en=1, wr_data is pushed to FIFO[wr_lane] if that lane's count<DEPTH, or if that lane pops at the same edge. Otherwise the write is dropped and overflow[wr_lane] is set to 1 (sticky until reset).
- wr_lane>=LANES: the write is ignored. No flag is set.
- Simultaneous push and pop on one lane leaves count unchanged. A push into an empty lane at a slot-load edge is not popped at that edge; the lane sends IDLE for that slot.
- FIFO pointers wrap modulo DEPTH. Count is $clog2(DEPTH)+1 bits wide.
- Lanes are fully independent apart from the shared bit_cnt and enable.

Test Plan:
- Reset/idle: hold reset_L=0 for 3 edges, then reset_L=1, enable=1, with no writes -> every lane outputs 1,0,1,1,1,1,0,0 repeating (8'hBC); out_valid=0; word_start high every 8th cycle; all outputs 0 while in reset.
- Single word: write 8'hA5 to lane 0 while enable=0, then raise enable -> lane 0 outputs 1,0,1,0,0,1,0,1 with out_valid=1 for exactly 8 cycles, then IDLE; lane 1 sends IDLE throughout.
- Multi-lane: queue 8'h0F,8'hF0 on lane 0 and 8'h3C on lane 1 -> slot 1 is 0F/3C, slot 2 is F0/BC (lane 1 out_valid=0), slot 3 is BC/BC; word_start is aligned on both lanes.
- Full/overflow: write 5 words to lane 1 (DEPTH=4) with enable=0 -> wr_full[1]=1 after the 4th write; the 5th is dropped and overflow[1]=1; overflow[0]=0; after enabling, the first 4 words are sent in order.
- Push at full with pop: with lane 0 full, write at a bit_cnt==0 edge with enable=1 -> write accepted, overflow stays 0, count stays 4.
- Abort: drop enable at bit 3 of word 8'h55, hold low 5 cycles, raise it -> outputs 0 while low; the next slot sends the following queued word or IDLE, never the remainder of 8'h55. Assert reset_L=0 mid-slot -> outputs 0 and FIFOs empty after that edge.
